// File: rtl/prog_mem.sv
// Loadable program memory for the fetch path: a boot loader streams the program in,
// then instruction fetches are served with a registered one-cycle read.
module prog_mem #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output logic              boot_done,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_fire_p0;
  logic              fetch_fire_p0;
  logic              hit_p0;

  logic              vld_p1;
  logic              fault_p1;
  logic [DATA_W-1:0] data_p1;

  // During LOAD the write pointer and the loaded length are the same count.
  function automatic logic addr_in_prog(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W:0]   len);
    return {1'b0, addr} < len;
  endfunction

  // Stage p0: request acceptance and range check against the current length
  assign ld_fire_p0    = ld_valid  && (state == LOAD);
  assign fetch_fire_p0 = fetch_req && (state == RUN);
  assign hit_p0        = addr_in_prog(fetch_addr, len_q);

  // Array is deliberately unreset; stale words stay unreachable behind prog_len.
  always_ff @(posedge clk) begin
    if (ld_fire_p0) begin
      mem[len_q[ADDR_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      len_q    <= '0;
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      data_p1  <= '0;
    end else begin
      // Stage p1: registered fetch response, computed from pre-reload state
      vld_p1   <= fetch_fire_p0;
      fault_p1 <= fetch_fire_p0 && !hit_p0;
      if (fetch_fire_p0) begin
        data_p1 <= hit_p0 ? mem[fetch_addr] : NOP_WORD;
      end

      case (state)
        LOAD: begin
          if (ld_fire_p0) begin
            len_q <= len_q + LEN_ONE;
            if (ld_last || (len_q == LAST_IDX)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (reload) begin
            state <= LOAD;
            len_q <= '0;
          end
        end
        default: begin
          state <= LOAD;
          len_q <= '0;
        end
      endcase
    end
  end

  assign ld_ready    = (state == LOAD);
  assign fetch_ready = (state == RUN);
  assign boot_done   = (state == RUN);
  assign prog_len    = len_q;
  assign fetch_valid = vld_p1;
  assign fetch_data  = data_p1;
  assign fetch_fault = fault_p1;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: a reference model predicts each fetch response into
// a queue, and responses are popped and compared when the DUT delivers them.
module tb_prog_mem;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 5;
  localparam int          DEPTH  = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              reload = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  logic              boot_done;
  logic [ADDR_W:0]   prog_len;

  prog_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .boot_done(boot_done), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] sb [$];
  logic [31:0] m_mem [DEPTH];
  logic [5:0]  m_len = '0;
  logic        m_run = 1'b0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ld_ready"},    64'(ld_ready),    64'(!m_run));
    chk({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(m_run));
    chk({tag, ".boot_done"},   64'(boot_done),   64'(m_run));
    chk({tag, ".prog_len"},    64'(prog_len),    64'(m_len));
  endtask

  // Advance one clock with the currently driven inputs and check every output.
  task automatic step(input string tag);
    logic        exp_v;
    logic [32:0] e;
    exp_v = 1'b0;
    if (fetch_req && m_run) begin
      exp_v = 1'b1;
      if ({1'b0, fetch_addr} < m_len) sb.push_back({1'b0, m_mem[fetch_addr]});
      else                            sb.push_back({1'b1, NOP});
    end
    if (ld_valid && !m_run) begin
      m_mem[m_len[4:0]] = ld_data;
      m_len = m_len + 6'd1;
      if (ld_last || m_len == 6'(DEPTH)) m_run = 1'b1;
    end else if (reload && m_run) begin
      m_run = 1'b0;
      m_len = '0;
    end
    @(posedge clk); #1;
    chk({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      m_data = e[31:0];
      chk({tag, ".fetch_data"},  64'(fetch_data),  64'(e[31:0]));
      chk({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(e[32]));
    end else begin
      chk({tag, ".held_data"},  64'(fetch_data),  64'(m_data));
      chk({tag, ".idle_fault"}, 64'(fetch_fault), 64'(0));
    end
    check_state(tag);
  endtask

  task automatic load_beat(input string tag, input logic [31:0] w, input logic last, input int gap);
    ld_valid = 1'b1; ld_data = w; ld_last = last;
    step(tag);
    idle();
    for (int g = 0; g < gap; g++) step({tag, ".gap"});
  endtask

  task automatic fetch(input string tag, input logic [4:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    step(tag);
    idle();
  endtask

  // Reset asserted mid-cycle, away from the clock edge; outputs must clear at once.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    m_run = 1'b0; m_len = '0; m_data = '0;
    sb.delete();
    chk({tag, ".rst_valid"}, 64'(fetch_valid), 64'(0));
    chk({tag, ".rst_data"},  64'(fetch_data),  64'(0));
    chk({tag, ".rst_fault"}, 64'(fetch_fault), 64'(0));
    check_state({tag, ".rst"});
    idle();
    @(posedge clk); #1;
    chk({tag, ".rst_hold_valid"}, 64'(fetch_valid), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] prog4 [4];
    prog4[0] = 32'h8040_0001; prog4[1] = 32'h8080_0002;
    prog4[2] = 32'h80C0_0003; prog4[3] = 32'h8100_0004;

    // Power-on reset
    idle();
    rst_n = 1'b0;
    #2;
    chk("por.fetch_valid", 64'(fetch_valid), 64'(0));
    chk("por.fetch_data",  64'(fetch_data),  64'(0));
    chk("por.fetch_fault", 64'(fetch_fault), 64'(0));
    check_state("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("por.idle");

    // Four-word load, last on beat 4, then back-to-back fetches
    for (int i = 0; i < 4; i++) load_beat("load4", prog4[i], i == 3, 0);
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = 5'(i);
      step("b2b");
    end
    idle();
    step("b2b.drain");
    fetch("oob4", 5'd4);
    fetch("oob31", 5'd31);
    step("oob.drain");

    // Reload and fetch in the same cycle: old contents answer, length clears
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd1;
    step("reload");
    idle();
    reload = 1'b1;
    step("reload_in_load");
    idle();
    load_beat("gap", 32'hA5A5_0001, 1'b0, 3);
    load_beat("gap", 32'hA5A5_0002, 1'b1, 3);
    fetch("new1", 5'd1);
    fetch("new2", 5'd2);
    step("new.drain");

    // Full-depth load without ld_last; extra beat must be refused
    reload = 1'b1;
    step("reload2");
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = 32'hC000_0000 + 32'(i * 7); ld_last = 1'b0;
      step("full");
    end
    step("full.extra");
    idle();
    fetch("full31", 5'd31);
    fetch("full0", 5'd0);
    step("full.drain");

    // Reset after two beats of a reload
    reload = 1'b1;
    step("reload3");
    idle();
    load_beat("mid", 32'h1111_1111, 1'b0, 0);
    load_beat("mid", 32'h2222_2222, 1'b0, 0);
    async_reset("midload");
    fetch("post_rst_fetch", 5'd0);
    step("post_rst.idle");

    // Reset while a fetch is presented in RUN
    load_beat("run2", 32'h3333_3333, 1'b0, 0);
    load_beat("run2", 32'h4444_4444, 1'b1, 0);
    fetch("run2.f1", 5'd1);
    fetch_req = 1'b1; fetch_addr = 5'd0;
    async_reset("midfetch");
    fetch("post_rst2_fetch", 5'd0);
    step("post_rst2.idle");
    load_beat("final", 32'h5555_5555, 1'b1, 0);
    fetch("final0", 5'd0);
    fetch("final1", 5'd1);
    step("final.drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
